// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: parametrised pipeline-stage register with a valid/ready
// handshake, an optional 2-entry skid buffer (registered in_ready), a flush
// that turns the stage into a bubble, and a saturating backpressure counter.
//
// The packed stage payload (PC, instruction, control, exception code, ...)
// is opaque here. It travels untouched as one DATA_W bus.
//
// SKID = 1 : main + skid registers, in_ready is a flop (breaks the ready path).
// SKID = 0 : single register, in_ready = !out_valid || out_ready (combinational).
//
// In both modes out_valid comes straight from state. It never depends
// combinationally on out_ready, so back-to-back stages cannot form a loop.

module pipe_stage_hs #(
    parameter int                DATA_W    = 64,
    parameter int                SKID      = 1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    // Saturation ceiling of the stall counter (all ones).
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    generate
        if (SKID != 0) begin : g_skid
            // Stage FSM. Each state's encoding equals its entry count.
            localparam logic [1:0] ST_EMPTY = 2'd0;
            localparam logic [1:0] ST_FULL  = 2'd1;
            localparam logic [1:0] ST_BUSY  = 2'd2;

            logic [1:0]        state_q, state_d;
            logic [DATA_W-1:0] main_q, main_d;
            logic [DATA_W-1:0] skid_q, skid_d;
            logic              rdy_q;
            logic              in_xfer;
            logic              out_xfer;

            // Handshakes use only registered ready/valid, never the other side's comb path.
            assign in_xfer  = in_valid && rdy_q;
            assign out_xfer = (state_q != ST_EMPTY) && out_ready;

            // Next-state and payload steering for the EMPTY/FULL/BUSY machine.
            always_comb begin
                // NOTE: every signal gets a default before the case, so no path can infer a latch.
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                case (state_q)
                    ST_EMPTY: begin
                        if (in_xfer) begin
                            state_d = ST_FULL;
                            main_d  = in_data;
                        end
                    end
                    ST_FULL: begin
                        if (in_xfer && out_xfer) begin
                            main_d = in_data;           // pass-through, stay FULL
                        end else if (in_xfer) begin
                            state_d = ST_BUSY;          // downstream stalled: park in skid
                            skid_d  = in_data;
                        end else if (out_xfer) begin
                            state_d = ST_EMPTY;
                        end
                    end
                    ST_BUSY: begin
                        // rdy_q is low here, so nothing can enter. Drain skid into main.
                        if (out_xfer) begin
                            state_d = ST_FULL;
                            main_d  = skid_q;
                        end
                    end
                    default: begin
                        state_d = ST_EMPTY;
                    end
                endcase
            end

            // State, payload and registered-ready update. Reset and flush both empty the stage.
            always_ff @(posedge clk) begin
                // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
                if (!rst || flush) begin
                    // NOTE: payload registers are reset because RESET_VAL is the visible bubble encoding downstream.
                    state_q <= ST_EMPTY;
                    main_q  <= RESET_VAL;
                    skid_q  <= RESET_VAL;
                    rdy_q   <= 1'b1;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                    rdy_q   <= (state_d != ST_BUSY);
                end
            end

            // Entry count derived from the FSM state.
            always_comb begin
                occupancy = 2'd0;
                case (state_q)
                    ST_FULL: occupancy = 2'd1;
                    ST_BUSY: occupancy = 2'd2;
                    default: occupancy = 2'd0;
                endcase
            end

            assign in_ready  = rdy_q;
            assign out_valid = (state_q != ST_EMPTY);
            assign out_data  = main_q;
        end else begin : g_single
            logic              valid_q;
            logic [DATA_W-1:0] data_q;
            logic              in_xfer;

            // Accept whenever the register is free or is being drained this cycle.
            assign in_ready = !valid_q || out_ready;
            assign in_xfer  = in_valid && in_ready;

            // Single payload register: load on accept, clear valid on drain-only.
            always_ff @(posedge clk) begin
                if (!rst || flush) begin
                    valid_q <= 1'b0;
                    data_q  <= RESET_VAL;
                end else if (in_xfer) begin
                    valid_q <= 1'b1;                    // covers simultaneous in+out reload
                    data_q  <= in_data;
                end else if (valid_q && out_ready) begin
                    valid_q <= 1'b0;
                end
            end

            assign out_valid = valid_q;
            assign out_data  = data_q;
            assign occupancy = {1'b0, valid_q};
        end
    endgenerate

    // Backpressure counter: counts stalled cycles, saturates, clear beats increment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
